// File: rtl/fp64_div_seq.sv
// fp64_div_seq: iterative restoring radix-2 binary64 divider, RNE, flush-to-zero; FP64_DIV_EARLY_OUT_EN enables power-of-two divisor bypass
module fp64_div_seq #(
  parameter int QBITS = 56
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] y,
  output logic        inexact,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;
  state_t state;
  logic [QBITS-1:0] q;
  logic [53:0] rem, rem_sub;
  logic [52:0] mb, mant;
  logic [53:0] mr;
  logic [10:0] ea, eb;
  logic [5:0] cnt;
  logic s, az, bz, ge, norm, g, st, rnd, early;
  logic a_zero, b_zero;
  logic signed [12:0] e_base, e_r;
  logic [63:0] ry;
  logic [3:0] rf;
  // denormal, NaN and Inf operands all behave as zero
  assign a_zero = (a[62:52] == 11'd0) | (&a[62:52]);
  assign b_zero = (b[62:52] == 11'd0) | (&b[62:52]);
`ifdef FP64_DIV_EARLY_OUT_EN
  assign early = b[51:0] == 52'd0;
`else
  assign early = 1'b0;
`endif
  always_comb begin
    ge = rem >= {1'b0, mb};
    rem_sub = ge ? rem - {1'b0, mb} : rem;
    norm = q[QBITS-1];
    mant = norm ? q[55:3] : q[54:2];
    g = norm ? q[2] : q[1];
    st = (norm ? |q[1:0] : q[0]) | (rem != 54'd0);
    e_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (norm ? 13'sd1023 : 13'sd1022);
    rnd = g & (st | mant[0]);
    mr = {1'b0, mant} + {53'd0, rnd};
    e_r = e_base + {12'd0, mr[53]};
    ry = {s, e_r[10:0], mr[53] ? mr[52:1] : mr[51:0]};
    rf = {g | st, 3'b000};
    if (az) begin
      ry = bz ? 64'd0 : {s, 63'd0};
      rf = 4'b0000;
    end else if (bz) begin
      ry = {s, 11'h7FF, 52'd0};
      rf = 4'b0001;
    end else if (e_r >= 13'sd2047) begin
      ry = {s, 11'h7FF, 52'd0};
      rf = 4'b1100;
    end else if (e_r <= 13'sd0) begin
      ry = 64'd0;
      rf = 4'b1010;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      y <= 64'd0;
      {inexact, overflow, underflow, div_by_zero} <= 4'b0000;
      q <= '0;
      rem <= '0;
      mb <= '0;
      ea <= '0;
      eb <= '0;
      s <= 1'b0;
      az <= 1'b0;
      bz <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          s <= a[63] ^ b[63];
          ea <= a[62:52];
          eb <= b[62:52];
          az <= a_zero;
          bz <= b_zero;
          mb <= {1'b1, b[51:0]};
          rem <= early ? 54'd0 : {2'b01, a[51:0]};
          q <= (early & ~a_zero & ~b_zero) ? {1'b1, a[51:0], 3'b000} : '0;
          cnt <= '0;
          state <= (a_zero | b_zero | early) ? ROUND : ITER;
        end
        ITER: begin
          q <= {q[QBITS-2:0], ge};
          rem <= rem_sub << 1;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(QBITS - 1)) state <= ROUND;
        end
        ROUND: begin
          y <= ry;
          {inexact, overflow, underflow, div_by_zero} <= rf;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp64_div_seq.sv
// tb_fp64_div_seq: scoreboard bench for fp64_div_seq using fixed vectors and host-double reference divides
module tb_fp64_div_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [63:0] a = 0, b = 0;
  logic in_ready, out_valid, inexact, overflow, underflow, div_by_zero;
  logic [63:0] y;
  typedef struct {
    logic [63:0] y;
    logic [3:0] f;
    logic [3:0] m;
    int lat;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0;

  fp64_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .inexact(inexact),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_zero(input logic [63:0] x);
    return x[62:52] == 11'd0 || x[62:52] == 11'h7FF;
  endfunction

  function automatic int lat_of(input logic [63:0] xa, input logic [63:0] xb);
    bit fast = is_zero(xa) || is_zero(xb);
`ifdef FP64_DIV_EARLY_OUT_EN
    fast = fast || xb[51:0] == 52'd0;
`endif
    return fast ? 2 : 58;
  endfunction

  task automatic send(input logic [63:0] xa, input logic [63:0] xb, input logic [63:0] ey,
                      input logic [3:0] ef, input logic [3:0] em, input int hold);
    exp_t e;
    int cyc, guard;
    e.y = ey; e.f = ef; e.m = em; e.lat = lat_of(xa, xb);
    sb.push_back(e);
    @(negedge clk);
    a = xa; b = xb; in_valid = 1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && cyc < 200) begin @(posedge clk); cyc++; @(negedge clk); end
    e = sb.pop_front();
    check("latency", 64'(cyc), 64'(e.lat));
    check("y", y, e.y);
    check("flags", {60'd0, {inexact, overflow, underflow, div_by_zero} & e.m}, {60'd0, e.f & e.m});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(negedge clk);
      check("hold_y", y, e.y);
      check("hold_flags", {60'd0, {inexact, overflow, underflow, div_by_zero} & e.m}, {60'd0, e.f & e.m});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("post_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra, rb;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y", y, 64'd0);
    check("rst_flags", {60'd0, inexact, overflow, underflow, div_by_zero}, 64'd0);
    send(64'h3FF0000000000000, 64'h4000000000000000, 64'h3FE0000000000000, 4'b0000, 4'hF, 0);
    send(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 4'b1000, 4'hF, 0);
    send(64'hBFF0000000000000, 64'h0000000000000000, 64'hFFF0000000000000, 4'b0001, 4'hF, 0);
    send(64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000, 4'b0000, 4'hF, 0);
    send(64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, 4'b1100, 4'hF, 0);
    send(64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 4'b1010, 4'hF, 0);
    send(64'h4018000000000000, 64'h4008000000000000, 64'h4000000000000000, 4'b0000, 4'hF, 0);
    send(64'h7FF8000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 4'b0000, 4'hF, 0);
    send(64'h3FF0000000000000, 64'h0000000000000001, 64'h7FF0000000000000, 4'b0001, 4'hF, 0);
    send(64'h8000000000000000, 64'h3FF0000000000000, 64'h8000000000000000, 4'b0000, 4'hF, 0);
    send(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 4'b1000, 4'hF, 10);
    for (int i = 0; i < 8; i++) begin
      ra = {1'($urandom), 11'($urandom_range(900, 1100)), 20'($urandom), 32'($urandom)};
      rb = {1'($urandom), 11'($urandom_range(900, 1100)), 20'($urandom), 32'($urandom)};
      send(ra, rb, $realtobits($bitstoreal(ra) / $bitstoreal(rb)), 4'b0000, 4'b0111, 0);
    end
    @(negedge clk);
    a = 64'h3FF0000000000000; b = 64'h4008000000000000; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_y", y, 64'd0);
    repeat (70) @(negedge clk);
    check("abort_no_output", {63'd0, out_valid}, 64'd0);
    send(64'h4018000000000000, 64'h4008000000000000, 64'h4000000000000000, 4'b0000, 4'hF, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
